// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Fetch-address consumer. Accepts one PC per handshake, keeps  |
// |               a single instruction-memory read outstanding, and buffers    |
// |               {pc, instruction} pairs in a small FIFO for decode. A flush  |
// |               empties the FIFO and discards any in-flight read.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk            in   1       clock, rising edge                           |
// |   reset          in   1       asynchronous, active-low reset               |
// |   flush          in   1       redirect; discard queued/in-flight fetches   |
// |   pc_in          in   ADDR_W  fetch address                                |
// |   pc_valid       in   1       pc_in is valid                               |
// |   pc_ready       out  1       pc_in accepted this cycle                    |
// |   imem_req       out  1       instruction-memory read request              |
// |   imem_addr      out  ADDR_W  read byte address                            |
// |   imem_ack       in   1       read data valid this cycle                   |
// |   imem_rdata     in   DATA_W  read data                                    |
// |   instr_valid    out  1       FIFO head valid                              |
// |   instr_ready    in   1       decode consumes head                         |
// |   instr_out      out  DATA_W  head instruction                             |
// |   instr_pc       out  ADDR_W  PC of head instruction                       |
// |   instr_misalign out  1       head PC was misaligned (optional)            |
// | Build option                                                               |
// |   FETCH_MISALIGN_CHECK_EN : when defined, misaligned PCs are not fetched;  |
// |   they are queued directly with instr_out=0 and instr_misalign=1. When     |
// |   undefined, pc[1:0] is forced to zero on imem_addr.                       |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              instr_misalign
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                rdy_q;     // holds pc_ready low until the first clock after reset
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic [ADDR_W-1:0]   head_pc_q, head_pc_d;

  logic [DATA_W-1:0]   mem_data [DEPTH];
  logic [ADDR_W-1:0]   mem_pc   [DEPTH];

  logic                w_pend;
  logic [CNT_W-1:0]    w_used;
  logic                w_accept;
  logic                w_ack_push;
  logic                w_push;
  logic                w_pop;
  logic [DATA_W-1:0]   w_push_data;
  logic                w_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic                mis_pend_q;
  logic                head_mis_q, head_mis_d;
  logic                mem_mis [DEPTH];

  assign w_pend       = mis_pend_q;
  assign w_misaligned = |pc_in[1:0];
  assign imem_addr    = pc_q;             // only aligned PCs are ever issued
  assign instr_misalign = head_mis_q;
`else
  assign w_pend       = 1'b0;
  assign w_misaligned = 1'b0;
  assign imem_addr    = {pc_q[ADDR_W-1:2], 2'b00};
`endif

  // A misaligned PC accepted last cycle still owns a slot until it is pushed.
  assign w_used      = count_q + CNT_W'(w_pend);
  assign pc_ready    = rdy_q && (state_q == ST_IDLE) && !flush && (w_used < C_DEPTH);
  assign w_accept    = pc_valid && pc_ready;
  assign w_ack_push  = (state_q == ST_REQ) && imem_ack && !flush;
  assign w_push      = !flush && (w_ack_push || w_pend);
  assign w_push_data = w_ack_push ? imem_rdata : '0;
  assign w_pop       = valid_q && instr_ready && !flush;

  assign imem_req    = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign instr_valid = valid_q;
  assign instr_out   = head_data_q;
  assign instr_pc    = head_pc_q;

  // Pointer, count and registered-head next state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    head_mis_d  = head_mis_q;
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
      count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
    // The new head is the entry being written only when it lands exactly at
    // the next read slot; a full FIFO never receives a push, so no overlap.
    if (count_d != '0) begin
      if (w_push && (wr_ptr_q == rd_ptr_d)) begin
        head_data_d = w_push_data;
        head_pc_d   = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        head_mis_d  = mis_pend_q;
`endif
      end else begin
        head_data_d = mem_data[rd_ptr_d];
        head_pc_d   = mem_pc[rd_ptr_d];
`ifdef FETCH_MISALIGN_CHECK_EN
        head_mis_d  = mem_mis[rd_ptr_d];
`endif
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_data[wr_ptr_q] <= w_push_data;
      mem_pc[wr_ptr_q]   <= pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      mem_mis[wr_ptr_q]  <= mis_pend_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      head_data_q <= '0;
      head_pc_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      head_mis_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= (count_d != '0);
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      head_mis_q  <= head_mis_d;
`endif
    end
  end

  // Request FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      rdy_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_pend_q <= 1'b0;
`endif
    end else begin
      rdy_q      <= 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_pend_q <= w_accept && w_misaligned;
`endif
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            pc_q <= pc_in;
            if (!w_misaligned) begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (flush) begin
            // An ack coinciding with the flush retires the read immediately.
            state_q <= imem_ack ? ST_IDLE : ST_DROP;
          end else if (imem_ack) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DROP: begin
          // The outstanding read completes here; its data is discarded.
          if (imem_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
